// File: rtl/cr_iu_gated_reg_wr_arb_if.sv
// Write/read bus between the IU/debug requesters, the gated register bank
// and the write-port arbiter.
interface cr_iu_gated_reg_wr_arb_if #(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = 2
);
    logic                    req0_vld;
    logic [IDX_W-1:0]        req0_idx;
    logic [31:0]             req0_data;
    logic                    req0_ack;
    logic                    req1_vld;
    logic [IDX_W-1:0]        req1_idx;
    logic [31:0]             req1_data;
    logic                    req1_ack;
    logic [NUM_REGS-1:0]     reg_write_en;
    logic [31:0]             reg_write_data;
    logic [32*NUM_REGS-1:0]  reg_dout_flat;
    logic [IDX_W-1:0]        rd_idx;
    logic [31:0]             rd_data;
    logic                    wr_idx_err;
    logic                    arb_idle;

    // Arbiter side
    modport slave (
        input  req0_vld, req0_idx, req0_data,
        output req0_ack,
        input  req1_vld, req1_idx, req1_data,
        output req1_ack,
        output reg_write_en, reg_write_data,
        input  reg_dout_flat, rd_idx,
        output rd_data, wr_idx_err, arb_idle
    );

    // Requester / register-bank side
    modport master (
        output req0_vld, req0_idx, req0_data,
        input  req0_ack,
        output req1_vld, req1_idx, req1_data,
        input  req1_ack,
        input  reg_write_en, reg_write_data,
        output reg_dout_flat, rd_idx,
        input  rd_data, wr_idx_err, arb_idle
    );
endinterface

// File: rtl/cr_iu_gated_reg_wr_arb.sv
// Round-robin write-port arbiter for a bank of gated-clock registers.
// The granted write is staged in flops so every register write enable
// (which doubles as its clock-gate enable) is glitch-free. Reads see the
// staged write through a forwarding path.
module cr_iu_gated_reg_wr_arb #(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = 2
) (
    input  logic                         forever_cpuclk,
    input  logic                         cpurst_b,
    cr_iu_gated_reg_wr_arb_if.slave      bus
);
    localparam int DATA_W = 32;
    localparam logic [IDX_W:0] NUM_REGS_W = NUM_REGS[IDX_W:0];

    logic                 rr_ptr;
    logic                 grant0_p0;
    logic                 grant1_p0;
    logic                 grant_p0;
    logic [IDX_W-1:0]     idx_p0;
    logic [DATA_W-1:0]    data_p0;
    logic                 idx_ok_p0;

    logic                 vld_p1;
    logic [IDX_W-1:0]     idx_p1;
    logic [DATA_W-1:0]    data_p1;
    logic [NUM_REGS-1:0]  en_p1;
    logic                 err_p1;

    logic [DATA_W-1:0]    rd_data;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == i[IDX_W-1:0]) r[i] = 1'b1;
        end
        return r;
    endfunction

    // ---- stage p0: arbitration and write select (combinational) ----
    // Select the winner: a lone requester wins, otherwise rr_ptr decides.
    always_comb begin
        grant0_p0 = bus.req0_vld & (~bus.req1_vld | ~rr_ptr);
        grant1_p0 = bus.req1_vld & (~bus.req0_vld |  rr_ptr);
        grant_p0  = grant0_p0 | grant1_p0;
        idx_p0    = grant1_p0 ? bus.req1_idx  : bus.req0_idx;
        data_p0   = grant1_p0 ? bus.req1_data : bus.req0_data;
        idx_ok_p0 = {1'b0, idx_p0} < NUM_REGS_W;
    end

    // ---- stage p1: staged write drives the register enables from flops ----
    // Capture the granted write; out-of-range indices are acked but only flag an error.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rr_ptr  <= 1'b0;
            vld_p1  <= 1'b0;
            idx_p1  <= '0;
            data_p1 <= '0;
            en_p1   <= '0;
            err_p1  <= 1'b0;
        end else if (grant_p0) begin
            rr_ptr  <= grant0_p0;
            vld_p1  <= idx_ok_p0;
            idx_p1  <= idx_p0;
            data_p1 <= data_p0;
            en_p1   <= idx_ok_p0 ? onehot(idx_p0) : '0;
            err_p1  <= ~idx_ok_p0;
        end else begin
            vld_p1  <= 1'b0;
            en_p1   <= '0;
            err_p1  <= 1'b0;
        end
    end

    // Read mux with forwarding of the write that lands at the end of this cycle.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.rd_idx == i[IDX_W-1:0]) rd_data = bus.reg_dout_flat[DATA_W*i +: DATA_W];
        end
        if (vld_p1 && (idx_p1 == bus.rd_idx)) rd_data = data_p1;
    end

    assign bus.req0_ack       = grant0_p0;
    assign bus.req1_ack       = grant1_p0;
    assign bus.reg_write_en   = en_p1;
    assign bus.reg_write_data = data_p1;
    assign bus.wr_idx_err     = err_p1;
    assign bus.rd_data        = rd_data;
    assign bus.arb_idle       = ~vld_p1 & ~bus.req0_vld & ~bus.req1_vld;

endmodule

// File: tb/tb_cr_iu_gated_reg_wr_arb.sv
// Directed bench: a 4-register and a 3-register arbiter see identical
// requests; each drives a small model of its gated register bank.
module tb_cr_iu_gated_reg_wr_arb;

    typedef struct {
        logic        r0v;
        logic [1:0]  r0i;
        logic [31:0] r0d;
        logic        r1v;
        logic [1:0]  r1i;
        logic [31:0] r1d;
        logic [1:0]  rdi;
        logic        a0;
        logic        a1;
        logic [3:0]  en_a;
        logic [31:0] wd;
        logic [31:0] rd_a;
        logic        idle_a;
        logic [2:0]  en_b;
        logic        err_b;
        logic [31:0] rd_b;
        logic        idle_b;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bank_load = 1'b1;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs [22];

    always #5 clk = ~clk;

    cr_iu_gated_reg_wr_arb_if #(.NUM_REGS(4), .IDX_W(2)) bus_a ();
    cr_iu_gated_reg_wr_arb_if #(.NUM_REGS(3), .IDX_W(2)) bus_b ();

    cr_iu_gated_reg_wr_arb #(.NUM_REGS(4), .IDX_W(2)) dut_a (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .bus            (bus_a)
    );

    cr_iu_gated_reg_wr_arb #(.NUM_REGS(3), .IDX_W(2)) dut_b (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .bus            (bus_b)
    );

    assign bus_b.req0_vld  = bus_a.req0_vld;
    assign bus_b.req0_idx  = bus_a.req0_idx;
    assign bus_b.req0_data = bus_a.req0_data;
    assign bus_b.req1_vld  = bus_a.req1_vld;
    assign bus_b.req1_idx  = bus_a.req1_idx;
    assign bus_b.req1_data = bus_a.req1_data;
    assign bus_b.rd_idx    = bus_a.rd_idx;

    // Gated register bank models: not reset, written when their enable is high.
    logic [31:0] bank_a [4];
    logic [31:0] bank_b [3];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bank_load) bank_a[i] <= 32'h100 + i;
            else if (bus_a.reg_write_en[i]) bank_a[i] <= bus_a.reg_write_data;
        end
        for (int i = 0; i < 3; i++) begin
            if (bank_load) bank_b[i] <= 32'h100 + i;
            else if (bus_b.reg_write_en[i]) bank_b[i] <= bus_b.reg_write_data;
        end
    end

    assign bus_a.reg_dout_flat = {bank_a[3], bank_a[2], bank_a[1], bank_a[0]};
    assign bus_b.reg_dout_flat = {bank_b[2], bank_b[1], bank_b[0]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic r0v, input logic [1:0] r0i, input logic [31:0] r0d,
        input logic r1v, input logic [1:0] r1i, input logic [31:0] r1d,
        input logic [1:0] rdi, input logic a0, input logic a1,
        input logic [3:0] en_a, input logic [31:0] wd, input logic [31:0] rd_a,
        input logic idle_a, input logic [2:0] en_b, input logic err_b,
        input logic [31:0] rd_b, input logic idle_b);
        vec_t v;
        v.r0v = r0v; v.r0i = r0i; v.r0d = r0d;
        v.r1v = r1v; v.r1i = r1i; v.r1d = r1d;
        v.rdi = rdi; v.a0 = a0; v.a1 = a1;
        v.en_a = en_a; v.wd = wd; v.rd_a = rd_a; v.idle_a = idle_a;
        v.en_b = en_b; v.err_b = err_b; v.rd_b = rd_b; v.idle_b = idle_b;
        return v;
    endfunction

    task automatic drive(input logic r0v, input logic [1:0] r0i, input logic [31:0] r0d,
                         input logic r1v, input logic [1:0] r1i, input logic [31:0] r1d,
                         input logic [1:0] rdi);
        bus_a.req0_vld = r0v; bus_a.req0_idx = r0i; bus_a.req0_data = r0d;
        bus_a.req1_vld = r1v; bus_a.req1_idx = r1i; bus_a.req1_data = r1d;
        bus_a.rd_idx = rdi;
    endtask

    initial begin
        //            r0v r0i r0d            r1v r1i r1d            rdi a0 a1 en_a     wd             rd_a           ia en_b    eb rd_b           ib
        vecs[0]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 4'b0000, 32'h0,         32'h100,       1, 3'b000, 0, 32'h100,       1);
        vecs[1]  = mk(1, 2, 32'hA5A5_0001, 0, 0, 32'h0,         2, 1, 0, 4'b0000, 32'h0,         32'h102,       0, 3'b000, 0, 32'h102,       0);
        vecs[2]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         2, 0, 0, 4'b0100, 32'hA5A5_0001, 32'hA5A5_0001, 0, 3'b100, 0, 32'hA5A5_0001, 0);
        vecs[3]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         2, 0, 0, 4'b0000, 32'hA5A5_0001, 32'hA5A5_0001, 1, 3'b000, 0, 32'hA5A5_0001, 1);
        vecs[4]  = mk(0, 0, 32'h0,         1, 0, 32'h55,        0, 0, 1, 4'b0000, 32'hA5A5_0001, 32'h100,       0, 3'b000, 0, 32'h100,       0);
        vecs[5]  = mk(1, 1, 32'h11,        1, 1, 32'h22,        1, 1, 0, 4'b0001, 32'h55,        32'h101,       0, 3'b001, 0, 32'h101,       0);
        vecs[6]  = mk(0, 0, 32'h0,         1, 1, 32'h22,        1, 0, 1, 4'b0010, 32'h11,        32'h11,        0, 3'b010, 0, 32'h11,        0);
        vecs[7]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 0, 4'b0010, 32'h22,        32'h22,        0, 3'b010, 0, 32'h22,        0);
        vecs[8]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 0, 4'b0000, 32'h22,        32'h22,        1, 3'b000, 0, 32'h22,        1);
        vecs[9]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 4'b0000, 32'h22,        32'h55,        1, 3'b000, 0, 32'h55,        1);
        vecs[10] = mk(1, 0, 32'hA0,        1, 3, 32'hB0,        0, 1, 0, 4'b0000, 32'h22,        32'h55,        0, 3'b000, 0, 32'h55,        0);
        vecs[11] = mk(1, 0, 32'hA1,        1, 3, 32'hB0,        0, 0, 1, 4'b0001, 32'hA0,        32'hA0,        0, 3'b001, 0, 32'hA0,        0);
        vecs[12] = mk(1, 0, 32'hA1,        1, 3, 32'hB1,        0, 1, 0, 4'b1000, 32'hB0,        32'hA0,        0, 3'b000, 1, 32'hA0,        0);
        vecs[13] = mk(1, 0, 32'hA2,        1, 3, 32'hB1,        0, 0, 1, 4'b0001, 32'hA1,        32'hA1,        0, 3'b001, 0, 32'hA1,        0);
        vecs[14] = mk(1, 0, 32'hA2,        1, 3, 32'hB2,        0, 1, 0, 4'b1000, 32'hB1,        32'hA1,        0, 3'b000, 1, 32'hA1,        0);
        vecs[15] = mk(1, 0, 32'hA3,        1, 3, 32'hB2,        0, 0, 1, 4'b0001, 32'hA2,        32'hA2,        0, 3'b001, 0, 32'hA2,        0);
        vecs[16] = mk(1, 0, 32'hA3,        0, 0, 32'h0,         0, 1, 0, 4'b1000, 32'hB2,        32'hA2,        0, 3'b000, 1, 32'hA2,        0);
        vecs[17] = mk(0, 0, 32'h0,         0, 0, 32'h0,         3, 0, 0, 4'b0001, 32'hA3,        32'hB2,        0, 3'b001, 0, 32'h0,         0);
        vecs[18] = mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 4'b0000, 32'hA3,        32'hA3,        1, 3'b000, 0, 32'hA3,        1);
        vecs[19] = mk(0, 0, 32'h0,         1, 3, 32'hDEAD_BEEF, 3, 0, 1, 4'b0000, 32'hA3,        32'hB2,        0, 3'b000, 0, 32'h0,         0);
        vecs[20] = mk(0, 0, 32'h0,         0, 0, 32'h0,         3, 0, 0, 4'b1000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 3'b000, 1, 32'h0,         1);
        vecs[21] = mk(0, 0, 32'h0,         0, 0, 32'h0,         3, 0, 0, 4'b0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 3'b000, 0, 32'h0,         1);

        drive(0, 0, 32'h0, 0, 0, 32'h0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en_a",   32'(bus_a.reg_write_en),   32'h0);
        chk("rst_wd_a",   bus_a.reg_write_data,      32'h0);
        chk("rst_idle_a", 32'(bus_a.arb_idle),       32'h1);
        chk("rst_err_a",  32'(bus_a.wr_idx_err),     32'h0);
        chk("rst_en_b",   32'(bus_b.reg_write_en),   32'h0);
        chk("rst_err_b",  32'(bus_b.wr_idx_err),     32'h0);
        rst_n = 1'b1;
        bank_load = 1'b0;

        for (int i = 0; i < 22; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].r0v, vecs[i].r0i, vecs[i].r0d, vecs[i].r1v, vecs[i].r1i, vecs[i].r1d, vecs[i].rdi);
            @(negedge clk);
            chk($sformatf("r%0d_ack0", i),   32'(bus_a.req0_ack),     32'(vecs[i].a0));
            chk($sformatf("r%0d_ack1", i),   32'(bus_a.req1_ack),     32'(vecs[i].a1));
            chk($sformatf("r%0d_en_a", i),   32'(bus_a.reg_write_en), 32'(vecs[i].en_a));
            chk($sformatf("r%0d_wd_a", i),   bus_a.reg_write_data,    vecs[i].wd);
            chk($sformatf("r%0d_rd_a", i),   bus_a.rd_data,           vecs[i].rd_a);
            chk($sformatf("r%0d_idle_a", i), 32'(bus_a.arb_idle),     32'(vecs[i].idle_a));
            chk($sformatf("r%0d_err_a", i),  32'(bus_a.wr_idx_err),   32'h0);
            chk($sformatf("r%0d_ack_b", i),  32'({bus_b.req1_ack, bus_b.req0_ack}), 32'({vecs[i].a1, vecs[i].a0}));
            chk($sformatf("r%0d_en_b", i),   32'(bus_b.reg_write_en), 32'(vecs[i].en_b));
            chk($sformatf("r%0d_err_b", i),  32'(bus_b.wr_idx_err),   32'(vecs[i].err_b));
            chk($sformatf("r%0d_rd_b", i),   bus_b.rd_data,           vecs[i].rd_b);
            chk($sformatf("r%0d_idle_b", i), 32'(bus_b.arb_idle),     32'(vecs[i].idle_b));
        end

        // Reset in the cycle after a grant: the staged write is dropped.
        @(posedge clk);
        #1;
        drive(1, 2, 32'h77, 0, 0, 32'h0, 2);
        @(negedge clk);
        chk("mr_ack0", 32'(bus_a.req0_ack), 32'h1);
        @(posedge clk);
        #1;
        drive(0, 0, 32'h0, 0, 0, 32'h0, 2);
        chk("mr_en_before", 32'(bus_a.reg_write_en), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_en_async",  32'(bus_a.reg_write_en),   32'h0);
        chk("mr_wd_async",  bus_a.reg_write_data,      32'h0);
        chk("mr_idle",      32'(bus_a.arb_idle),       32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mr_reg_kept",  bus_a.rd_data,             32'hA5A5_0001);
        drive(1, 0, 32'h1, 1, 1, 32'h2, 2);
        @(negedge clk);
        chk("mr_rr_ack0",   32'(bus_a.req0_ack),       32'h1);
        chk("mr_rr_ack1",   32'(bus_a.req1_ack),       32'h0);
        @(posedge clk);
        #1;
        drive(0, 0, 32'h0, 1, 1, 32'h2, 2);
        @(negedge clk);
        chk("mr_rr2_ack1",  32'(bus_a.req1_ack),       32'h1);
        @(posedge clk);
        #1;
        drive(0, 0, 32'h0, 0, 0, 32'h0, 1);
        @(negedge clk);
        chk("mr_last_en",   32'(bus_a.reg_write_en),   32'h2);
        chk("mr_last_rd",   bus_a.rd_data,             32'h2);

        // Ten quiet cycles: no enable activity at all.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("q%0d_en_a", c),   32'(bus_a.reg_write_en), 32'h0);
            chk($sformatf("q%0d_idle_a", c), 32'(bus_a.arb_idle),     32'h1);
            chk($sformatf("q%0d_en_b", c),   32'(bus_b.reg_write_en), 32'h0);
        end
        chk("q_reg1", bank_a[1], 32'h2);
        chk("q_reg0", bank_a[0], 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
